// File: rtl/aes_cipher_stream.sv
// rtl/aes_cipher_stream.sv - iterative AES encryptor, one round per clock, valid/ready on both sides
module aes_cipher_stream #(
  parameter int Nk = 4,
  localparam int Nr = Nk + 6
) (
  input  logic                   clks,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [127:0]           plainText,
  input  logic [128*(Nr+1)-1:0]  keys,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [127:0]           encryptedText,
  output logic                   busy
);

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, RUN, FINAL, HOLD} cipherState_e;

  cipherState_e            fsmState;
  logic [128*(Nr+1)-1:0]   keyReg;
  logic [127:0]            stateReg;
  logic [4:0]              round;
  logic [127:0]            shifted;
  logic [127:0]            roundOut;
  logic [127:0]            finalOut;
  logic                    accept;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte i of a block sits at [127-8i -: 8]; column c holds bytes 4c..4c+3
  function automatic logic [127:0] subShift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] mixColumns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  always_comb begin
    shifted  = subShift(stateReg);
    roundOut = mixColumns(shifted) ^ keyReg[128*int'(round) +: 128];
    finalOut = shifted ^ keyReg[128*Nr +: 128];
  end

  assign in_ready = (fsmState == IDLE) || (fsmState == HOLD && out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (fsmState == RUN) || (fsmState == FINAL);

  always_ff @(posedge clks) begin
    if (!reset_n) begin
      fsmState      <= IDLE;
      keyReg        <= '0;
      stateReg      <= '0;
      round         <= '0;
      encryptedText <= '0;
      out_valid     <= 1'b0;
    end else begin
      case (fsmState)
        IDLE, HOLD: begin
          if (accept) begin
            keyReg    <= keys;
            stateReg  <= plainText ^ keys[127:0];
            round     <= 5'd1;
            out_valid <= 1'b0;
            fsmState  <= RUN;
          end else if (fsmState == HOLD && out_ready) begin
            out_valid <= 1'b0;
            fsmState  <= IDLE;
          end
        end
        RUN: begin
          stateReg <= roundOut;
          round    <= round + 5'd1;
          if (round == 5'(Nr - 1)) fsmState <= FINAL;
        end
        FINAL: begin
          encryptedText <= finalOut;
          out_valid     <= 1'b1;
          round         <= 5'd0;
          fsmState      <= HOLD;
        end
        default: fsmState <= IDLE;
      endcase
    end
  end

endmodule
